// File: rtl/pipe_retire_trace.sv
`default_nettype none
// ============================================================================
// pipe_retire_trace : WB-stage retire event classifier + FWFT trace FIFO
// Revision 1.0
// ============================================================================
module pipe_retire_trace #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [5:0]       wb_opcode,
  input  logic [5:0]       wb_funct,
  input  logic [31:0]      wb_wd,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [CNT_W-1:0] trc_cycle,
  output logic [31:0]      trc_pc,
  output logic [3:0]       trc_class,
  output logic [31:0]      trc_wd,
  output logic [AW:0]      fifo_level,
  output logic [15:0]      drop_cnt
);

  localparam logic [AW:0]      c_FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      c_LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]    c_PTR_ONE    = AW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] cycle;
    logic [31:0]      pc;
    logic [3:0]       cls;
    logic [31:0]      wd;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [15:0]      drop_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] cls_d;
  logic       push_req, full, pop, do_push, drop;
  entry_t     head;

  always_comb begin
    cls_d = 4'd15;
    unique case (wb_opcode)
      6'd0: begin
        unique case (wb_funct)
          6'd32:   cls_d = 4'd1;
          6'd34:   cls_d = 4'd2;
          6'd36:   cls_d = 4'd3;
          6'd37:   cls_d = 4'd4;
          6'd0:    cls_d = 4'd5;
          6'd42:   cls_d = 4'd6;
          default: cls_d = 4'd15;
        endcase
      end
      6'd18:   cls_d = 4'd7;
      6'd35:   cls_d = 4'd8;
      6'd43:   cls_d = 4'd9;
      6'd4:    cls_d = 4'd10;
      6'd2:    cls_d = 4'd11;
      6'd3:    cls_d = 4'd12;
      default: cls_d = 4'd15;
    endcase
  end

  assign push_req = trace_en & wb_valid;
  assign full     = (level_q == c_FULL_LEVEL);
  assign pop      = trc_valid & trc_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{cycle: cnt_q, pc: wb_pc, cls: cls_d, wd: wb_wd};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + c_CNT_ONE;
      if (do_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      unique case ({do_push, pop})
        2'b10:   level_q <= level_q + c_LVL_ONE;
        2'b01:   level_q <= level_q - c_LVL_ONE;
        default: level_q <= level_q;
      endcase
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign head       = mem_q[rd_ptr_q];
  assign trc_valid  = (level_q != '0);
  assign trc_cycle  = trc_valid ? head.cycle : '0;
  assign trc_pc     = trc_valid ? head.pc    : '0;
  assign trc_class  = trc_valid ? head.cls   : '0;
  assign trc_wd     = trc_valid ? head.wd    : '0;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_retire_trace.sv
`default_nettype none
// ============================================================================
// tb_pipe_retire_trace : directed stimulus with queue-based reference model
// Revision 1.0
// ============================================================================
module tb_pipe_retire_trace;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0, rst = 1'b0;
  logic             trace_en = 1'b0, wb_valid = 1'b0, trc_ready = 1'b0;
  logic [31:0]      wb_pc = '0, wb_wd = '0;
  logic [5:0]       wb_opcode = '0, wb_funct = '0;
  logic             trc_valid;
  logic [CNT_W-1:0] trc_cycle;
  logic [31:0]      trc_pc, trc_wd;
  logic [3:0]       trc_class;
  logic [AW:0]      fifo_level;
  logic [15:0]      drop_cnt;

  pipe_retire_trace #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_opcode(wb_opcode), .wb_funct(wb_funct), .wb_wd(wb_wd),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_cycle(trc_cycle),
    .trc_pc(trc_pc), .trc_class(trc_class), .trc_wd(trc_wd),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [31:0] wd;
  } ev_t;

  ev_t         mq[$];
  ev_t         popped[$];
  int unsigned m_drop;
  logic [31:0] m_cnt;
  bit          live = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Instruction table: {opcode, funct (-1 = any), class}
  int tbl [12][3] = '{'{0,32,1}, '{0,34,2}, '{0,36,3}, '{0,37,4}, '{0,0,5}, '{0,42,6},
                      '{18,-1,7}, '{35,-1,8}, '{43,-1,9}, '{4,-1,10}, '{2,-1,11}, '{3,-1,12}};

  function automatic logic [3:0] spec_class(input logic [5:0] op, input logic [5:0] fn);
    for (int k = 0; k < 12; k++)
      if (int'(op) == tbl[k][0] && (tbl[k][1] < 0 || int'(fn) == tbl[k][1]))
        return 4'(tbl[k][2]);
    return 4'd15;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each clock edge from the spec rules.
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_drop = 0;
      m_cnt  = '0;
      live   = 1'b1;
    end else if (live) begin
      automatic int sz  = mq.size();
      automatic bit pp  = (sz != 0) && trc_ready;
      automatic bit psh = trace_en && wb_valid;
      if (pp) void'(mq.pop_front());
      if (psh) begin
        if (sz < DEPTH || pp) mq.push_back('{m_cnt, wb_pc, spec_class(wb_opcode, wb_funct), wb_wd});
        else if (m_drop < 65535) m_drop++;
      end
      m_cnt = m_cnt + 32'd1;
    end
  end

  // Log of what the DUT actually hands over.
  always @(posedge clk) begin
    if (live && rst && trc_valid && trc_ready)
      popped.push_back('{trc_cycle, trc_pc, trc_class, trc_wd});
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("m_valid", 64'(trc_valid), 64'(mq.size() != 0));
      chk("m_level", 64'(fifo_level), 64'(mq.size()));
      chk("m_drop",  64'(drop_cnt), 64'(m_drop));
      if (mq.size() != 0) begin
        chk("m_cycle", 64'(trc_cycle), 64'(mq[0].cyc));
        chk("m_pc",    64'(trc_pc),    64'(mq[0].pc));
        chk("m_class", 64'(trc_class), 64'(mq[0].cls));
        chk("m_wd",    64'(trc_wd),    64'(mq[0].wd));
      end else begin
        chk("m_zero", {trc_cycle, trc_pc}, 64'd0);
        chk("m_zero2", {28'd0, trc_class, trc_wd}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] wd);
    wb_valid = 1'b1; wb_pc = pc; wb_opcode = op; wb_funct = fn; wb_wd = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    automatic logic [5:0] ops [12] = '{18, 35, 43, 4, 2, 3, 0, 0, 0, 0, 0, 0};
    automatic logic [5:0] fns [12] = '{32, 0, 0, 0, 0, 0, 34, 36, 37, 0, 42, 8};
    automatic logic [3:0] exp [12] = '{7, 8, 9, 10, 11, 12, 2, 3, 4, 5, 6, 15};
    automatic logic [31:0] hold_pc, hold_cyc;

    // 1. Reset then a single event
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    chk("rst_valid", 64'(trc_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    trace_en = 1'b1;
    step(); step(); step();
    drive(32'h8, 6'd0, 6'd32, 32'd5);
    step();
    wb_valid = 1'b0;
    chk("t1_valid", 64'(trc_valid), 64'd1);
    chk("t1_class", 64'(trc_class), 64'd1);
    chk("t1_pc",    64'(trc_pc), 64'h8);
    chk("t1_wd",    64'(trc_wd), 64'd5);
    chk("t1_cycle", 64'(trc_cycle), 64'd3);
    chk("t1_level", 64'(fifo_level), 64'd1);

    // 2. Classification sweep
    trc_ready = 1'b1;
    step();
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      drive(32'h100 + 32'(4*i), ops[i], fns[i], 32'(i));
      step();
    end
    wb_valid = 1'b0;
    repeat (4) step();
    chk("t2_count", 64'(popped.size()), 64'd12);
    for (int i = 0; i < 12 && i < popped.size(); i++)
      chk($sformatf("t2_class%0d", i), 64'(popped[i].cls), 64'(exp[i]));

    // 3. Overflow, then 4. full with simultaneous push/pop
    trc_ready = 1'b0;
    popped.delete();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(32'h1000 + 32'(4*i), 6'd35, 6'd0, 32'(i));
      step();
    end
    chk("t3_level", 64'(fifo_level), 64'd16);
    chk("t3_drop",  64'(drop_cnt), 64'd3);
    trc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'h2000 + 32'(4*i), 6'd43, 6'd0, 32'(100 + i));
      step();
      chk("t4_level", 64'(fifo_level), 64'd16);
      chk("t4_drop",  64'(drop_cnt), 64'd3);
    end
    wb_valid = 1'b0;
    repeat (20) step();
    chk("t3_count", 64'(popped.size()), 64'd21);
    if (popped.size() == 21) begin
      for (int i = 0; i < 16; i++) begin
        chk("t3_pc",  64'(popped[i].pc), 64'(32'h1000 + 32'(4*i)));
        chk("t3_cyc", 64'(popped[i].cyc), 64'(popped[0].cyc + 32'(i)));
      end
      for (int i = 16; i < 21; i++)
        chk("t4_pc", 64'(popped[i].pc), 64'(32'h2000 + 32'(4*(i-16))));
    end

    // 5. Filtering and backpressure
    popped.delete();
    trace_en = 1'b0;
    drive(32'h3000, 6'd0, 6'd32, 32'd1);
    repeat (3) step();
    chk("t5_filter", 64'(fifo_level), 64'd0);
    trace_en = 1'b1;
    wb_valid = 1'b0;
    repeat (3) step();
    chk("t5_bubble", 64'(fifo_level), 64'd0);
    chk("t5_none",   64'(popped.size()), 64'd0);
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h4000 + 32'(4*i), 6'd0, 6'd37, 32'(i));
      step();
    end
    wb_valid = 1'b0;
    step();
    hold_pc  = trc_pc;
    hold_cyc = trc_cycle;
    step();
    chk("t5_hold_pc",  64'(trc_pc), 64'h4000);
    chk("t5_hold_cyc", 64'(trc_cycle), 64'(hold_cyc));
    chk("t5_hold_pc2", 64'(trc_pc), 64'(hold_pc));
    for (int i = 0; i < 12; i++) begin
      trc_ready = (i % 2 == 1);
      step();
    end
    chk("t5_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk("t5_pc", 64'(popped[i].pc), 64'(32'h4000 + 32'(4*i)));

    // 6. Reset mid-operation
    trc_ready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(32'h5000 + 32'(4*i), 6'd2, 6'd0, 32'(i));
      step();
    end
    wb_valid  = 1'b0;
    trc_ready = 1'b1;
    repeat (9) step();
    trc_ready = 1'b0;
    chk("t6_pre_level", 64'(fifo_level), 64'd7);
    chk("t6_pre_drop",  64'(drop_cnt), 64'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_valid", 64'(trc_valid), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    drive(32'h6000, 6'd3, 6'd0, 32'h77);
    step();
    wb_valid = 1'b0;
    chk("t6_cycle", 64'(trc_cycle), 64'd0);
    chk("t6_class", 64'(trc_class), 64'd12);
    chk("t6_lvl1",  64'(fifo_level), 64'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_retire_trace.md
Name: pipe_retire_trace

Overview:
- Hardware retire-trace recorder for the mips_pipeline CPU.
- Each cycle it samples the writeback (WB) stage retire event: PC, opcode, funct and write-back data.
- Each event is classified into a compact instruction code, stamped with a cycle count and pushed into a FIFO.
- Entries drain over a valid/ready stream to an on-chip logger or UART bridge, so runs can be traced on hardware as well as in simulation.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, FIFO pointer width; equals log2(DEPTH).
- CNT_W, 32, width of the cycle stamp.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low: rst==0 at a posedge resets the block.
- trace_en  input  1  1 = record retire events; 0 = ignore them. Draining and the cycle counter are unaffected.
- wb_valid  input  1  a real (non-bubble) instruction retires this cycle.
- wb_pc  input  32  PC of the retiring instruction.
- wb_opcode  input  6  instruction[31:26].
- wb_funct  input  6  instruction[5:0].
- wb_wd  input  32  register-file write data at WB.
- trc_valid  output  1  head entry available.
- trc_ready  input  1  consumer accepts the head entry.
- trc_cycle  output  CNT_W  cycle stamp of the head entry.
- trc_pc  output  32  PC of the head entry.
- trc_class  output  4  instruction class of the head entry.
- trc_wd  output  32  write data of the head entry.
- fifo_level  output  AW+1  number of occupied entries, 0..DEPTH.
- drop_cnt  output  16  events lost because the FIFO was full.

Behaviour:
- Reset (rst==0 at posedge):
  - Pointers, fifo_level, drop_cnt and the cycle counter clear to 0.
  - trc_valid=0; trc_cycle, trc_pc, trc_class and trc_wd read 0.
  - FIFO storage contents are don't-care.
  - Reset mid-drain discards all entries.
- Cycle counter:
  - Reads 0 in the first cycle after reset releases.
  - Increments by 1 every clk, wrapping at 2^CNT_W.
  - An event sampled in a cycle is stamped with the counter value of that same cycle.
- Classification (combinational on inputs, registered into the FIFO):
  - opcode 0 with funct 32 -> ADD=1, 34 -> SUB=2, 36 -> AND=3, 37 -> OR=4, 0 -> SLL=5, 42 -> SLT=6.
  - opcode 18 -> SLTI=7, 35 -> LW=8, 43 -> SW=9, 4 -> BEQ=10, 2 -> J=11, 3 -> JAL=12.
  - Any other opcode/funct -> UNKNOWN=15. Codes 0 and 13-14 are never produced.
- Push:
  - push_req = trace_en & wb_valid.
  - The entry is written at the posedge.
- Pop:
  - pop = trc_valid & trc_ready, taking effect at the posedge.
- Outputs are first-word-fall-through from the head entry:
  - A push into an empty FIFO at edge N gives trc_valid=1 after edge N, one cycle of latency.
  - trc_* hold stable while trc_valid=1 and trc_ready=0.
- Full FIFO (fifo_level==DEPTH):
  - push_req without pop: the event is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - push_req with pop in the same cycle: both happen, level stays DEPTH, no drop.
- Empty FIFO:
  - trc_valid=0 and trc_ready is ignored.
  - A push alone makes the level 1.
- Pointers wrap modulo DEPTH.
- Level changes per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Ordering: entries leave in strict push order, with no reordering or merging.
- trace_en changes take effect on the same cycle's sample and never affect entries already stored.

Test Plan:
1. Reset then a single event:
   - Stimulus: rst=0 for 2 cycles, then rst=1; in cycle 3 drive wb_valid=1, pc=0x0000_0008, opcode=0, funct=32, wd=5, trace_en=1, trc_ready=0.
   - Required: next cycle trc_valid=1, trc_class=1, trc_pc=0x8, trc_wd=5, trc_cycle=3, fifo_level=1.
2. Classification sweep:
   - Stimulus: retire opcodes 18, 35, 43, 4, 2, 3 and 0/funct 34, 36, 37, 0, 42 and 0/funct 8, with trc_ready=1.
   - Required: classes emerge in order 7, 8, 9, 10, 11, 12, 2, 3, 4, 5, 6, 15.
3. Overflow:
   - Stimulus: trc_ready=0, wb_valid=1 for DEPTH+3 cycles.
   - Required: fifo_level=16, drop_cnt=3; draining yields the first 16 events in order with consecutive trc_cycle.
4. Full with simultaneous push and pop:
   - Stimulus: FIFO full, trc_ready=1 and wb_valid=1 for 5 cycles.
   - Required: level stays 16, drop_cnt unchanged, 5 entries popped in order.
5. Filtering and backpressure:
   - Stimulus: trace_en=0 with wb_valid=1, then wb_valid=0 bubbles; then a push while trc_ready toggles 0/1.
   - Required: no entries recorded for the first two; outputs hold stable while ready=0; each entry is popped exactly once.
6. Reset mid-operation:
   - Stimulus: 7 entries queued, drop_cnt=2, rst=0 for 1 cycle.
   - Required: trc_valid=0, fifo_level=0, drop_cnt=0, and the next event is stamped trc_cycle=0 relative to the release.
